// File: rtl/button_debouncer_if.sv
// -----------------------------------------------------------------------------
// button_debouncer_if
//   Groups the button-side signals of one debouncer instance.
//
//   Signals:
//     Input_1     raw, asynchronous, possibly bouncing button level
//     Result      debounced, registered level
//     Rise_Pulse  one-cycle pulse when Result goes 0->1
//     Fall_Pulse  one-cycle pulse when Result goes 1->0 (button press)
//
//   Modports:
//     master  drives Input_1, observes the debounced outputs
//     slave   the debouncer itself
// -----------------------------------------------------------------------------
interface button_debouncer_if;
   logic Input_1;
   logic Result;
   logic Rise_Pulse;
   logic Fall_Pulse;

   modport master (
      output Input_1,
      input  Result,
      input  Rise_Pulse,
      input  Fall_Pulse
   );

   modport slave (
      input  Input_1,
      output Result,
      output Rise_Pulse,
      output Fall_Pulse
   );
endinterface : button_debouncer_if

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Synchronises a raw active-low button level into the GlobalClock domain and
//   debounces it: Result only follows the synchronised input once it has held
//   a new value long enough. Single-cycle Rise_Pulse / Fall_Pulse mark each
//   committed change. All outputs come straight from flops.
//
//   Parameters:
//     STABLE_CYCLES  stability window, legal range 1 .. 2**CNT_WIDTH-1
//     CNT_WIDTH      width of the stability counter
//     RESET_LEVEL    Result and synchroniser value under reset (1 = released)
//
//   Ports:
//     GlobalClock    system clock, rising edge
//     Reset          asynchronous, active-high reset
//     btn            button_debouncer_if.slave (Input_1 in; Result,
//                    Rise_Pulse, Fall_Pulse out)
// -----------------------------------------------------------------------------
module button_debouncer #(
   parameter int unsigned STABLE_CYCLES = 50000,
   parameter int unsigned CNT_WIDTH     = 16,
   parameter logic        RESET_LEVEL   = 1'b1
) (
   input  logic                GlobalClock,
   input  logic                Reset,
   button_debouncer_if.slave   btn
);

   localparam int unsigned SYNC_STAGES = 2;

   localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = '0;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_TARGET = STABLE_CYCLES[CNT_WIDTH-1:0];

   typedef enum logic {
      IDLE  = 1'b0,
      CHECK = 1'b1
   } state_t;

   // --------------------------------------------------------------------------
   // Two-flop synchroniser. sync_reg[0] is the metastability catcher, only
   // the last stage is allowed to feed the FSM.
   // --------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_d;
   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   sync_q2;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign sync_d[gi] = btn.Input_1;
         end else begin : g_chain
            assign sync_d[gi] = sync_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge GlobalClock or posedge Reset) begin
      if (Reset) begin
         sync_reg <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         sync_reg <= sync_d;
      end
   end

   assign sync_q2 = sync_reg[SYNC_STAGES-1];

   // --------------------------------------------------------------------------
   // Debounce FSM
   // --------------------------------------------------------------------------
   state_t               state_reg,  state_next;
   logic [CNT_WIDTH-1:0] cnt_reg,    cnt_next;
   logic                 result_reg, result_next;
   logic                 rise_reg,   rise_next;
   logic                 fall_reg,   fall_next;

   always_ff @(posedge GlobalClock or posedge Reset) begin
      if (Reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= CNT_ZERO;
         result_reg <= RESET_LEVEL;
         rise_reg   <= 1'b0;
         fall_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         result_reg <= result_next;
         rise_reg   <= rise_next;
         fall_reg   <= fall_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      result_next = result_reg;
      rise_next   = 1'b0;
      fall_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            // The entry edge already counts as the first differing sample.
            if (sync_q2 != result_reg) begin
               state_next = CHECK;
               cnt_next   = CNT_ONE;
            end
         end

         CHECK: begin
            if (sync_q2 == result_reg) begin
               // Bounced back before the window filled: discard the attempt.
               state_next = IDLE;
               cnt_next   = CNT_ZERO;
            end else if (cnt_reg == CNT_TARGET) begin
               // Commit. The counter stops at the target, so it never wraps.
               result_next = sync_q2;
               rise_next   = sync_q2;
               fall_next   = ~sync_q2;
               state_next  = IDLE;
               cnt_next    = CNT_ZERO;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end

         default: begin
            state_next = IDLE;
            cnt_next   = CNT_ZERO;
         end
      endcase
   end

   assign btn.Result     = result_reg;
   assign btn.Rise_Pulse = rise_reg;
   assign btn.Fall_Pulse = fall_reg;

endmodule : button_debouncer
